// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the two-requester burst write arbiter and its FIFO wrapper.
package fifo_wr_arbiter_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int LEN_W_DEF  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/fifo_flag.sv
// Generic synchronous FIFO with full/empty flags and show-ahead read data.
// Latency: a written word is visible on dout the cycle after the write.
// Backpressure: writes while full and reads while empty are ignored.
module fifo_flag #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic [DW-1:0] din,
    input  logic          rd,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   count;
    logic          do_wr;
    logic          do_rd;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;
    assign dout  = mem[rp];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wp] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_wr) begin
                wp <= wp + 1'b1;
            end
            if (do_rd) begin
                rp <= rp + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fifo_wr_sys.sv
// Arbiter plus the 16-deep byte FIFO it feeds; full flag throttles the arbiter.
// Latency: as the arbiter for writes; read data is show-ahead from the FIFO.
// Backpressure: FIFO full stalls the active burst until a read frees a slot.
module fifo_wr_sys
    import fifo_wr_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [LEN_W_DEF-1:0] len0,
    input  logic [LEN_W_DEF-1:0] len1,
    input  logic [7:0]           d0,
    input  logic [7:0]           d1,
    input  logic                 rd,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 ack0,
    output logic                 ack1,
    output logic                 busy,
    output logic [7:0]           dout,
    output logic                 full,
    output logic                 empty
);

    logic       fifo_wr;
    logic [7:0] fifo_din;

    fifo_wr_arbiter #(
        .DATA_W (8),
        .LEN_W  (LEN_W_DEF)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .len0      (len0),
        .len1      (len1),
        .d0        (d0),
        .d1        (d1),
        .fifo_full (full),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .ack0      (ack0),
        .ack1      (ack1),
        .fifo_wr   (fifo_wr),
        .fifo_din  (fifo_din),
        .busy      (busy)
    );

    fifo_flag #(
        .DW    (8),
        .DEPTH (16),
        .AW    (4)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (fifo_wr),
        .din   (fifo_din),
        .rd    (rd),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting whole bursts (len+1 words) from two requesters into one FIFO.
// Latency: grant registered one cycle after req in IDLE; first word may be written in the grant cycle.
// Backpressure: fifo_full stalls the burst with the grant held; an IDLE cycle separates bursts.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [LEN_W-1:0]  len0,
    input  logic [LEN_W-1:0]  len1,
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    input  logic              fifo_full,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic              fifo_wr,
    output logic [DATA_W-1:0] fifo_din,
    output logic              busy
);

    localparam logic [LEN_W:0] CNT_ONE = (LEN_W+1)'(1);

    arb_state_t     state;
    arb_state_t     state_nxt;
    logic [LEN_W:0] cnt;
    logic [LEN_W:0] cnt_nxt;
    logic           last_srv;
    logic           last_srv_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            last_srv <= 1'b1;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            last_srv <= last_srv_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        last_srv_nxt = last_srv;
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        ack0         = 1'b0;
        ack1         = 1'b0;
        fifo_wr      = 1'b0;
        fifo_din     = '0;
        case (state)
            IDLE: begin
                // On a tie, requester 0 wins only if requester 1 was served last
                if (req0 && (!req1 || last_srv)) begin
                    state_nxt    = GNT0;
                    cnt_nxt      = {1'b0, len0} + CNT_ONE;
                    last_srv_nxt = 1'b0;
                end else if (req1) begin
                    state_nxt    = GNT1;
                    cnt_nxt      = {1'b0, len1} + CNT_ONE;
                    last_srv_nxt = 1'b1;
                end
            end
            GNT0, GNT1: begin
                gnt0     = (state == GNT0);
                gnt1     = (state == GNT1);
                fifo_din = (state == GNT0) ? d0 : d1;
                fifo_wr  = !fifo_full;
                ack0     = (state == GNT0) && !fifo_full;
                ack1     = (state == GNT1) && !fifo_full;
                if (!fifo_full) begin
                    cnt_nxt = cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = gnt0 | gnt1;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized bench for fifo_wr_arbiter against a burst-ownership reference model.
module tb_fifo_wr_arbiter;

    localparam int DW    = 8;
    localparam int LW    = 2;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1;
    logic [LW-1:0] len0, len1;
    logic [DW-1:0] d0, d1;
    logic          fifo_full;
    logic          gnt0, gnt1, ack0, ack1, fifo_wr, busy;
    logic [DW-1:0] fifo_din;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.DATA_W(DW), .LEN_W(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .len0      (len0),
        .len1      (len1),
        .d0        (d0),
        .d1        (d1),
        .fifo_full (fifo_full),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .ack0      (ack0),
        .ack1      (ack1),
        .fifo_wr   (fifo_wr),
        .fifo_din  (fifo_din),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference: who owns the FIFO (0 none, 1 req0, 2 req1), words left, last served
    int m_own, m_rem, m_last;
    int bursts[2];
    int blen[2];
    logic [DW-1:0] wq0[$];
    logic [DW-1:0] wq1[$];
    logic [DW-1:0] env_q[$];
    logic [DW-1:0] exp_words[4];
    bit  force_full, rd_pending, rand_mode;
    int  wr_count, gnt_cycles;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_own  = 0;
        m_rem  = 0;
        m_last = 1;
    endtask

    function automatic logic [31:0] out_vec();
        return {18'b0, gnt0, gnt1, busy, ack0, ack1, fifo_wr, fifo_din};
    endfunction

    task automatic drive();
        if (rand_mode) begin
            for (int i = 0; i < 2; i++) begin
                if (bursts[i] == 0 && m_own != i + 1 && $urandom_range(0, 3) == 0) begin
                    bursts[i] = 1;
                    blen[i]   = int'($urandom_range(0, 3));
                end
            end
            if (wq0.size() == 0) wq0.push_back(DW'($urandom));
            if (wq1.size() == 0) wq1.push_back(DW'($urandom));
            force_full = ($urandom_range(0, 4) == 0);
            rd_pending = (env_q.size() > 0) && ($urandom_range(0, 2) == 0);
        end
        req0      = (bursts[0] > 0) && (m_own != 1);
        req1      = (bursts[1] > 0) && (m_own != 2);
        len0      = LW'(blen[0]);
        len1      = LW'(blen[1]);
        d0        = (wq0.size() > 0) ? wq0[0] : '0;
        d1        = (wq1.size() > 0) ? wq1[0] : '0;
        fifo_full = (env_q.size() >= DEPTH) || force_full;
    endtask

    task automatic cycle();
        logic          e_wr, e_g0, e_g1;
        logic [DW-1:0] e_din;
        int            pick;
        drive();
        @(negedge clk);
        e_g0  = (m_own == 1);
        e_g1  = (m_own == 2);
        e_wr  = (m_own != 0) && !fifo_full;
        e_din = e_g0 ? d0 : (e_g1 ? d1 : '0);
        chk("cycle_outputs", out_vec(),
            {18'b0, e_g0, e_g1, e_g0 | e_g1, e_g0 & e_wr, e_g1 & e_wr, e_wr, e_din});
        if (gnt0 || gnt1) gnt_cycles++;
        if (rd_pending && env_q.size() > 0) void'(env_q.pop_front());
        rd_pending = 1'b0;
        if (fifo_wr) begin
            wr_count++;
            if (env_q.size() < DEPTH) env_q.push_back(fifo_din);
        end
        if (ack0 && wq0.size() > 0) void'(wq0.pop_front());
        if (ack1 && wq1.size() > 0) void'(wq1.pop_front());
        if (!rst) begin
            model_reset();
        end else if (m_own == 0) begin
            pick = 0;
            if (req0 && req1) pick = (m_last == 1) ? 1 : 2;
            else if (req0)    pick = 1;
            else if (req1)    pick = 2;
            if (pick != 0) begin
                m_own  = pick;
                m_rem  = ((pick == 1) ? int'(len0) : int'(len1)) + 1;
                m_last = pick - 1;
                bursts[pick-1]--;
            end
        end else if (e_wr) begin
            m_rem--;
            if (m_rem == 0) m_own = 0;
        end
        @(posedge clk);
        #1;
    endtask

    // Runs until all bursts are done and, if asked, the FIFO model is drained
    task automatic run_until(input string tag, input int budget, input bit drain);
        int n = 0;
        while ((m_own != 0 || bursts[0] > 0 || bursts[1] > 0 || (drain && env_q.size() > 0))
               && n < budget) begin
            if (drain) rd_pending = (env_q.size() > 0);
            cycle();
            n++;
        end
        chk({tag, "_within_budget"}, 32'(n < budget), 32'd1);
    endtask

    initial begin
        rst = 1'b1; req0 = 0; req1 = 0; len0 = '0; len1 = '0; d0 = '0; d1 = '0;
        fifo_full = 0; force_full = 0; rd_pending = 0; rand_mode = 0;
        bursts = '{0, 0}; blen = '{0, 0}; wr_count = 0; gnt_cycles = 0;
        model_reset();
        #1 rst = 1'b0;
        #1 chk("reset_outputs", out_vec(), 32'd0);
        @(posedge clk); #1;
        cycle();
        rst = 1'b1;

        // Single requester, 4-word burst, readback order
        wq0 = '{8'h11, 8'h22, 8'h33, 8'h44};
        blen[0] = 3; bursts[0] = 1; wr_count = 0; gnt_cycles = 0;
        run_until("single", 20, 1'b0);
        cycle();
        chk("single_writes", 32'(wr_count), 32'd4);
        chk("single_gnt_cycles", 32'(gnt_cycles), 32'd4);
        chk("single_level", 32'(env_q.size()), 32'd4);
        exp_words = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) chk("single_readback", 32'(env_q[i]), 32'(exp_words[i]));
        run_until("single_drain", 20, 1'b1);

        // Contention from reset: strict alternation 0,1,0,1
        rst = 1'b0; #1; model_reset();
        cycle();
        rst = 1'b1;
        wq0 = '{8'hA0, 8'hB0}; wq1 = '{8'hA1, 8'hB1};
        blen = '{0, 0}; bursts = '{2, 2};
        run_until("alternate", 30, 1'b0);
        chk("alt_level", 32'(env_q.size()), 32'd4);
        exp_words = '{8'hA0, 8'hA1, 8'hB0, 8'hB1};
        for (int i = 0; i < 4; i++) chk("alt_order", 32'(env_q[i]), 32'(exp_words[i]));
        run_until("alt_drain", 20, 1'b1);

        // Backpressure: three full cycles in the middle of a 3-word burst
        wq1 = '{8'hC1, 8'hC2, 8'hC3};
        blen[1] = 2; bursts[1] = 1; wr_count = 0;
        cycle();
        cycle();
        force_full = 1;
        repeat (3) cycle();
        chk("bp_stall_writes", 32'(wr_count), 32'd1);
        chk("bp_gnt1_held", 32'(gnt1), 32'd1);
        force_full = 0;
        run_until("backpressure", 20, 1'b0);
        chk("bp_total_writes", 32'(wr_count), 32'd3);
        exp_words = '{8'hC1, 8'hC2, 8'hC3, 8'h00};
        for (int i = 0; i < 3; i++) chk("bp_order", 32'(env_q[i]), 32'(exp_words[i]));
        run_until("bp_drain", 20, 1'b1);

        // Reset in the middle of a burst with two words left
        wq0 = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
        blen[0] = 3; bursts[0] = 1;
        repeat (3) cycle();
        chk("rst_pre_gnt0", 32'(gnt0), 32'd1);
        rst = 1'b0;
        #1 chk("rst_async_outputs", out_vec(), 32'd0);
        model_reset(); bursts[0] = 0; wq0.delete();
        wq1 = '{8'hE1}; blen[1] = 0; bursts[1] = 1;
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        chk("rst_new_gnt1", 32'(gnt1), 32'd1);
        run_until("post_reset", 10, 1'b0);
        chk("rst_level", 32'(env_q.size()), 32'd3);
        exp_words = '{8'hD0, 8'hD1, 8'hE1, 8'h00};
        for (int i = 0; i < 3; i++) chk("rst_kept_words", 32'(env_q[i]), 32'(exp_words[i]));
        run_until("rst_drain", 20, 1'b1);

        // Fill a 16-deep FIFO, then a fifth burst stalls until one read
        wq0.delete();
        for (int i = 0; i < 20; i++) wq0.push_back(DW'(i + 1));
        blen[0] = 3; bursts[0] = 4; wr_count = 0;
        run_until("fill", 60, 1'b0);
        chk("fill_writes", 32'(wr_count), 32'd16);
        chk("fill_level", 32'(env_q.size()), 32'd16);
        bursts[0] = 1; wr_count = 0;
        repeat (6) cycle();
        chk("full_stall_writes", 32'(wr_count), 32'd0);
        chk("full_stall_gnt0", 32'(gnt0), 32'd1);
        rd_pending = 1;
        cycle();
        repeat (4) cycle();
        chk("full_one_write", 32'(wr_count), 32'd1);
        chk("full_word17", 32'(env_q[DEPTH-1]), 32'd17);
        run_until("fill_drain", 80, 1'b1);

        // Randomized traffic against the reference model
        rand_mode = 1;
        repeat (400) cycle();
        rand_mode = 0; force_full = 0;
        run_until("random_drain", 100, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
